// File: rtl/serial_pkg.sv
// Shared types and constants for the serial deserializer.
// Optional parity support is enabled by defining SERIAL_DESER_PARITY_EN.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_SHIFT = 2'd1;
    localparam logic [STATE_W-1:0] S_PAR   = 2'd2;

endpackage

// File: rtl/deser_hold_reg.sv
// One-entry valid/ready hold register with sticky overrun detection.
// Carries a parity status bit alongside each word.
module deser_hold_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_perr,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             parity_err,
    output logic             overrun
);

    logic pop;
    logic load;

    assign pop  = out_valid & out_ready;
    assign load = push & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
        end else if (load) begin
            out_data   <= push_data;
            out_valid  <= 1'b1;
            parity_err <= push_perr;
        end else if (pop) begin
            out_valid  <= 1'b0;
        end
    end

    // A word arriving while the entry is full and not draining is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (clr) begin
            overrun <= 1'b0;
        end else if (push && !load) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/serial_deser.sv
// Serial-in, parallel-out receiver: FSM, bit counter and shift register.
// Define SERIAL_DESER_PARITY_EN to expect an even-parity bit after each word.
module serial_deser
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             serial_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nx;
    logic [WIDTH-1:0]   sh;
    logic [WIDTH-1:0]   sh_nx;
    logic [WIDTH-1:0]   sh_shift;
    logic               push;
    logic [WIDTH-1:0]   push_data;
    logic               push_perr;

    always_comb begin
        if (MSB_FIRST) begin
            sh_shift = {sh[WIDTH-2:0], serial_in};
        end else begin
            sh_shift = {serial_in, sh[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sh_nx     = sh;
        push      = 1'b0;
        push_data = sh_shift;
        push_perr = 1'b0;
        if (clr) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            sh_nx    = '0;
        end else if (bit_valid) begin
            case (state)
                S_IDLE, S_SHIFT: begin
                    sh_nx = sh_shift;
                    if (cnt == LAST) begin
                        cnt_nx = '0;
`ifdef SERIAL_DESER_PARITY_EN
                        state_nx = S_PAR;
`else
                        state_nx = S_IDLE;
                        push     = 1'b1;
`endif
                    end else begin
                        cnt_nx   = cnt + 1'b1;
                        state_nx = S_SHIFT;
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                // Data bits are complete; this bit is the parity bit.
                S_PAR: begin
                    state_nx  = S_IDLE;
                    push      = 1'b1;
                    push_data = sh;
                    push_perr = ^{sh, serial_in};
                end
`endif
                default: begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            sh    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sh    <= sh_nx;
        end
    end

    assign busy = (state != S_IDLE);

    logic hold_perr;

    deser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .push_data (push_data),
        .push_perr (push_perr),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .parity_err(hold_perr),
        .overrun   (overrun)
    );

`ifdef SERIAL_DESER_PARITY_EN
    assign parity_err = hold_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: an MSB-first and an LSB-first instance
// receive the same bit stream; expected words are hand-computed.
module tb_serial_deser;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       serial_in;
    logic       bit_valid;
    logic       out_ready;

    logic [7:0] data_m;
    logic       valid_m;
    logic       ovr_m;
    logic       busy_m;
    logic       perr_m;

    logic [7:0] data_l;
    logic       valid_l;
    logic       ovr_l;
    logic       busy_l;
    logic       perr_l;

    int n_chk  = 0;
    int n_fail = 0;

    serial_deser #(
        .WIDTH    (8),
        .MSB_FIRST(1'b1)
    ) u_m (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .serial_in (serial_in),
        .bit_valid (bit_valid),
        .out_data  (data_m),
        .out_valid (valid_m),
        .out_ready (out_ready),
        .overrun   (ovr_m),
        .busy      (busy_m),
        .parity_err(perr_m)
    );

    serial_deser #(
        .WIDTH    (8),
        .MSB_FIRST(1'b0)
    ) u_l (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .serial_in (serial_in),
        .bit_valid (bit_valid),
        .out_data  (data_l),
        .out_valid (valid_l),
        .out_ready (out_ready),
        .overrun   (ovr_l),
        .busy      (busy_l),
        .parity_err(perr_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Streams w starting at bit 7 (msb=1) or bit 0 (msb=0).
    task automatic send(input logic [7:0] w, input logic msb,
                        input logic p, input logic gaps,
                        input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            serial_in = msb ? w[7-i] : w[i];
`ifndef SERIAL_DESER_PARITY_EN
            if (i == 7) out_ready = rdy_last;
`endif
            if (gaps && i != 7) begin
                @(negedge clk);
                bit_valid = 1'b0;
                serial_in = ~serial_in;
            end
        end
`ifdef SERIAL_DESER_PARITY_EN
        @(negedge clk);
        bit_valid = 1'b1;
        serial_in = p;
        out_ready = rdy_last;
`else
        if (p) serial_in = serial_in;
`endif
        @(negedge clk);
        bit_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic partial4();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            serial_in = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        serial_in = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        chk("rst_data", 32'(data_m), 32'h00);
        chk("rst_valid", 32'(valid_m), 32'h0);
        chk("rst_ovr", 32'(ovr_m), 32'h0);
        chk("rst_busy", 32'(busy_m), 32'h0);
        chk("rst_perr", 32'(perr_m), 32'h0);
        chk("rst_data_l", 32'(data_l), 32'h00);
        rst = 1'b0;

        // Basic A5, MSB-first, with exact latency and busy checks.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("b_busy_pre", 32'(busy_m), 32'h0);
            else        chk("b_busy_mid", 32'(busy_m), 32'h1);
            chk("b_valid_pre", 32'(valid_m), 32'h0);
            bit_valid = 1'b1;
            serial_in = (i == 0 || i == 2 || i == 5 || i == 7);
        end
`ifdef SERIAL_DESER_PARITY_EN
        @(negedge clk);
        chk("b_busy_par", 32'(busy_m), 32'h1);
        chk("b_valid_par", 32'(valid_m), 32'h0);
        serial_in = 1'b0;
`endif
        @(negedge clk);
        bit_valid = 1'b0;
        chk("b_valid", 32'(valid_m), 32'h1);
        chk("b_data", 32'(data_m), 32'hA5);
        chk("b_busy_post", 32'(busy_m), 32'h0);
        chk("b_perr", 32'(perr_m), 32'h0);
        pop();
        chk("b_pop_valid", 32'(valid_m), 32'h0);
        chk("b_pop_data", 32'(data_m), 32'hA5);

        // LSB-first 3C with idle gaps carrying inverted junk bits.
        send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("g_data_l", 32'(data_l), 32'h3C);
        chk("g_valid_l", 32'(valid_l), 32'h1);
        chk("g_data_m", 32'(data_m), 32'h3C);
        pop();

        // Asymmetric word exposes bit ordering: 12 MSB-first is 48 LSB-first.
        send(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("o_data_m", 32'(data_m), 32'h12);
        chk("o_data_l", 32'(data_l), 32'h48);
        pop();

        // Backpressure and overrun.
        send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ov_ovr0", 32'(ovr_m), 32'h0);
        send(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ov_data", 32'(data_m), 32'h11);
        chk("ov_valid", 32'(valid_m), 32'h1);
        chk("ov_ovr1", 32'(ovr_m), 32'h1);
        pop();
        chk("ov_pop_valid", 32'(valid_m), 32'h0);
        chk("ov_sticky", 32'(ovr_m), 32'h1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ov_clr", 32'(ovr_m), 32'h0);
        chk("ov_clr_valid", 32'(valid_m), 32'h0);

        // Pop and completion in the same cycle.
        send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sp_data", 32'(data_m), 32'h22);
        chk("sp_valid", 32'(valid_m), 32'h1);
        chk("sp_ovr", 32'(ovr_m), 32'h0);
        pop();

        // clr mid-word; the bit presented with clr is dropped.
        partial4();
        chk("c_busy", 32'(busy_m), 32'h1);
        @(negedge clk);
        clr       = 1'b1;
        bit_valid = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        bit_valid = 1'b0;
        chk("c_busy_clr", 32'(busy_m), 32'h0);
        send(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("c_data_m", 32'(data_m), 32'hF0);
        chk("c_data_l", 32'(data_l), 32'h0F);
        chk("c_ovr", 32'(ovr_m), 32'h0);

        // Async reset mid-word with a held word and overrun set.
        send(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r_ovr_pre", 32'(ovr_m), 32'h1);
        partial4();
        #2 rst = 1'b1;
        #1;
        chk("r_data", 32'(data_m), 32'h00);
        chk("r_valid", 32'(valid_m), 32'h0);
        chk("r_ovr", 32'(ovr_m), 32'h0);
        chk("r_busy", 32'(busy_m), 32'h0);
        chk("r_data_l", 32'(data_l), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r_after", 32'(data_m), 32'hA5);
        chk("r_after_v", 32'(valid_m), 32'h1);
        pop();

`ifdef SERIAL_DESER_PARITY_EN
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("p_bad_data", 32'(data_m), 32'hA5);
        chk("p_bad_valid", 32'(valid_m), 32'h1);
        chk("p_bad_perr", 32'(perr_m), 32'h1);
        pop();
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("p_ok_perr", 32'(perr_m), 32'h0);
        pop();
`else
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("p_tied", 32'(perr_m), 32'h0);
        pop();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
